// File: rtl/trivium_pkg.sv
// Shared constants and FSM encoding for the Trivium keystream core.
package trivium_pkg;

  localparam int unsigned STATE_W    = 288;
  localparam int unsigned KEY_W      = 80;
  localparam int unsigned IV_W       = 80;
  localparam int unsigned WARMUP_DEF = 1152;
  localparam int unsigned KIV_W      = KEY_W + IV_W;
  localparam int unsigned CFG_BYTES  = KIV_W / 8;

  // Register boundaries: A = s1..s93, B = s94..s177, C = s178..s288
  localparam int unsigned A_LEN = 93;
  localparam int unsigned B_END = 177;

  // Tap positions in 1-based Trivium numbering (s_k lives at state bit k-1)
  localparam int unsigned T1_LIN_A = 66;
  localparam int unsigned T1_LIN_B = 93;
  localparam int unsigned T1_AND_A = 91;
  localparam int unsigned T1_AND_B = 92;
  localparam int unsigned T1_FB    = 171;
  localparam int unsigned T2_LIN_A = 162;
  localparam int unsigned T2_LIN_B = 177;
  localparam int unsigned T2_AND_A = 175;
  localparam int unsigned T2_AND_B = 176;
  localparam int unsigned T2_FB    = 264;
  localparam int unsigned T3_LIN_A = 243;
  localparam int unsigned T3_LIN_B = 288;
  localparam int unsigned T3_AND_A = 286;
  localparam int unsigned T3_AND_B = 287;
  localparam int unsigned T3_FB    = 69;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    INIT = 2'd2,
    RUN  = 2'd3
  } fsm_e;

endpackage

// File: rtl/trivium_keystream_gen_round.sv
// One combinational Trivium round: produces the keystream bit and the shifted state.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] state_o,
  output logic               z_o
);

  logic t1_lin, t2_lin, t3_lin;
  logic t1_fb, t2_fb, t3_fb;

  // Output bit from the linear taps, feedback adds the AND term and cross-register tap
  always_comb begin
    t1_lin = state_i[T1_LIN_A-1] ^ state_i[T1_LIN_B-1];
    t2_lin = state_i[T2_LIN_A-1] ^ state_i[T2_LIN_B-1];
    t3_lin = state_i[T3_LIN_A-1] ^ state_i[T3_LIN_B-1];
    z_o    = t1_lin ^ t2_lin ^ t3_lin;
    t1_fb  = t1_lin ^ (state_i[T1_AND_A-1] & state_i[T1_AND_B-1]) ^ state_i[T1_FB-1];
    t2_fb  = t2_lin ^ (state_i[T2_AND_A-1] & state_i[T2_AND_B-1]) ^ state_i[T2_FB-1];
    t3_fb  = t3_lin ^ (state_i[T3_AND_A-1] & state_i[T3_AND_B-1]) ^ state_i[T3_FB-1];
    state_o = {state_i[STATE_W-2:B_END], t2_fb,
               state_i[B_END-2:A_LEN],   t1_fb,
               state_i[A_LEN-2:0],       t3_fb};
  end

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream core: byte-serial key/IV load, warm-up, WORD_W bits per stream transfer.
module trivium_keystream_gen
  import trivium_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned WARMUP = WARMUP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_data,
  output logic              cfg_ready,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [WORD_W-1:0] ks_data,
  output logic              busy
);

  localparam int unsigned INIT_CYC = WARMUP / WORD_W;
  localparam int unsigned CNT_W    = $clog2(INIT_CYC + 1);
  localparam int unsigned BCNT_W   = $clog2(CFG_BYTES);

  fsm_e                fsm_q, fsm_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [KIV_W-1:0]    kiv_q, kiv_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]    round_cnt_q, round_cnt_d;
  logic                ks_valid_q, ks_valid_d;
  logic [WORD_W-1:0]   ks_data_q, ks_data_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                busy_q, busy_d;

  logic [STATE_W-1:0]  round_chain [WORD_W+1];
  logic [WORD_W-1:0]   z_c;
  logic [KIV_W-1:0]    kiv_next_c;
  logic [STATE_W-1:0]  init_state_c;

  assign round_chain[0] = state_q;

  // WORD_W rounds chained per cycle; round j supplies keystream bit j
  for (genvar j = 0; j < WORD_W; j++) begin : g_round
    trivium_round u_round (
      .state_i (round_chain[j]),
      .state_o (round_chain[j+1]),
      .z_o     (z_c[j])
    );
  end

  // Byte 0 ends up in the low bits; the final byte is folded in combinationally
  always_comb begin
    kiv_next_c   = {cfg_data, kiv_q[KIV_W-1:8]};
    init_state_c = '0;
    init_state_c[KEY_W-1:0]           = kiv_next_c[KEY_W-1:0];
    init_state_c[A_LEN+IV_W-1:A_LEN]  = kiv_next_c[KIV_W-1:KEY_W];
    init_state_c[STATE_W-1:STATE_W-3] = 3'b111;
  end

  // Next-state and datapath control
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    kiv_d       = kiv_q;
    byte_cnt_d  = byte_cnt_q;
    round_cnt_d = round_cnt_q;
    ks_valid_d  = ks_valid_q;
    ks_data_d   = ks_data_q;

    if (cfg_start) begin
      fsm_d      = LOAD;
      byte_cnt_d = '0;
      ks_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        IDLE: fsm_d = IDLE;
        LOAD: begin
          if (cfg_valid) begin
            kiv_d = kiv_next_c;
            if (byte_cnt_q == BCNT_W'(CFG_BYTES - 1)) begin
              fsm_d       = INIT;
              byte_cnt_d  = '0;
              round_cnt_d = '0;
              state_d     = init_state_c;
            end else begin
              byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
          end
        end
        INIT: begin
          state_d = round_chain[WORD_W];
          if (round_cnt_q != CNT_W'(INIT_CYC)) round_cnt_d = round_cnt_q + CNT_W'(1);
          if (round_cnt_q == CNT_W'(INIT_CYC - 1)) fsm_d = RUN;
        end
        RUN: begin
          if (!ks_valid_q || ks_ready) begin
            state_d    = round_chain[WORD_W];
            ks_data_d  = z_c;
            ks_valid_d = 1'b1;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end

    cfg_ready_d = (fsm_d == LOAD);
    busy_d      = (fsm_d == LOAD) || (fsm_d == INIT);
  end

  // State registers; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      kiv_q       <= '0;
      byte_cnt_q  <= '0;
      round_cnt_q <= '0;
      ks_valid_q  <= 1'b0;
      ks_data_q   <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      kiv_q       <= kiv_d;
      byte_cnt_q  <= byte_cnt_d;
      round_cnt_q <= round_cnt_d;
      ks_valid_q  <= ks_valid_d;
      ks_data_q   <= ks_data_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign ks_valid  = ks_valid_q;
  assign ks_data   = ks_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen at WORD_W = 1, 8 and 64 sharing one stimulus bus.
module tb_trivium_keystream_gen;

  localparam logic [79:0] K1 = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] I1 = 80'hECBB76B09AFF71D0D151;
  localparam logic [79:0] K2 = 80'h0123456789ABCDEF0011;
  localparam logic [79:0] I2 = 80'hFEDCBA98765432100FF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        ks_ready = 1'b1;

  logic        cfg_ready8, ks_valid8, busy8;
  logic [7:0]  ks_data8;
  logic        cfg_ready1, ks_valid1, busy1;
  logic [0:0]  ks_data1;
  logic        cfg_ready64, ks_valid64, busy64;
  logic [63:0] ks_data64;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  bit busy_cnt_en = 1'b0;
  bit ref_bits [2048];

  always #5 clk = ~clk;

  trivium_keystream_gen #(.WORD_W(8), .WARMUP(1152)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready8), .ks_valid(ks_valid8), .ks_ready(ks_ready),
    .ks_data(ks_data8), .busy(busy8));

  trivium_keystream_gen #(.WORD_W(1), .WARMUP(1152)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready1), .ks_valid(ks_valid1), .ks_ready(ks_ready),
    .ks_data(ks_data1), .busy(busy1));

  trivium_keystream_gen #(.WORD_W(64), .WARMUP(1152)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready64), .ks_valid(ks_valid64), .ks_ready(ks_ready),
    .ks_data(ks_data64), .busy(busy64));

  // Busy-cycle counter for the warm-up timing check
  always @(negedge clk) if (busy_cnt_en && busy8) busy_cnt++;

  // Reference Trivium in the three-register (A/B/C) form; fills ref_bits after 1152 rounds
  task automatic model_gen(input logic [79:0] key, input logic [79:0] iv);
    logic [93:1]  a;
    logic [84:1]  b;
    logic [111:1] c;
    logic t1, t2, t3, z;
    a = {13'b0, key};
    b = {4'b0, iv};
    c = {3'b111, 108'b0};
    for (int r = 0; r < 1152 + 2048; r++) begin
      t1 = a[66] ^ a[93];
      t2 = b[69] ^ b[84];
      t3 = c[66] ^ c[111];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (a[91] & a[92]) ^ b[78];
      t2 = t2 ^ (b[82] & b[83]) ^ c[87];
      t3 = t3 ^ (c[109] & c[110]) ^ a[69];
      a = {a[92:1], t3};
      b = {b[83:1], t1};
      c = {c[110:1], t2};
      if (r >= 1152) ref_bits[r-1152] = z;
    end
  endtask

  function automatic logic [7:0] exp8(input int w);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = ref_bits[w*8+j];
    return r;
  endfunction

  function automatic logic [63:0] exp64(input int w);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = ref_bits[w*64+j];
    return r;
  endfunction

  // Start pulse then 20 bytes; returns at the negedge after byte 19 was accepted
  task automatic load_keyiv(input logic [79:0] key, input logic [79:0] iv, input bit junk,
                            output bit rdy_ok);
    logic [159:0] kiv;
    kiv = {iv, key};
    rdy_ok = 1'b1;
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_valid = junk;
    cfg_data  = 8'hA5;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready8 !== 1'b1) rdy_ok = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = kiv[i*8 +: 8];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ks_valid8, busy8, cfg_ready8} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl8 got=%b exp=000", {ks_valid8, busy8, cfg_ready8});
    end
    n_checks++;
    if (ks_data8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_data8 got=%h exp=00", ks_data8);
    end
    n_checks++;
    if ({ks_valid1, busy1, cfg_ready1, ks_data1} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_dut1 got=%b exp=0000", {ks_valid1, busy1, cfg_ready1, ks_data1});
    end
    n_checks++;
    if ({ks_valid64, busy64, cfg_ready64} !== 3'b000 || ks_data64 !== 64'h0) begin
      n_fail++; $display("FAIL reset_dut64 got=%b/%h exp=000/0", {ks_valid64, busy64, cfg_ready64}, ks_data64);
    end
  endtask

  task automatic test_warmup();
    int n;
    bit rdy_ok;
    model_gen(K1, I1);
    ks_ready = 1'b1;
    busy_cnt = 0;
    busy_cnt_en = 1'b1;
    load_keyiv(K1, I1, 1'b0, rdy_ok);
    n_checks++;
    if (rdy_ok !== 1'b1) begin
      n_fail++; $display("FAIL warmup_cfg_ready got=%b exp=1", rdy_ok);
    end
    n_checks++;
    if ({busy8, cfg_ready8, ks_valid8} !== 3'b100) begin
      n_fail++; $display("FAIL warmup_init_flags got=%b exp=100", {busy8, cfg_ready8, ks_valid8});
    end
    n = 0;
    while (!ks_valid8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    busy_cnt_en = 1'b0;
    n_checks++;
    if (n != 145) begin
      n_fail++; $display("FAIL warmup_first_valid got=%0d exp=145", n);
    end
    n_checks++;
    if (busy_cnt != 164) begin
      n_fail++; $display("FAIL warmup_busy_cycles got=%0d exp=164", busy_cnt);
    end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(w)) begin
        n_fail++; $display("FAIL warmup_word%0d got=%b/%h exp=1/%h", w, ks_valid8, ks_data8, exp8(w));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    ks_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(16)) begin
        n_fail++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", i, ks_valid8, ks_data8, exp8(16));
      end
    end
    ks_ready = 1'b1;
    for (int w = 16; w < 32; w++) begin
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(w)) begin
        n_fail++; $display("FAIL bp_resume_word%0d got=%b/%h exp=1/%h", w, ks_valid8, ks_data8, exp8(w));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_golden();
    bit          rdy_ok;
    logic        got1 [1024];
    logic [63:0] got64 [16];
    int w1, w8, w64, bad1, bad8, bad64, badp;
    w1 = 0; w8 = 0; w64 = 0; bad1 = 0; bad8 = 0; bad64 = 0; badp = 0;
    model_gen(80'h0, 80'h0);
    ks_ready = 1'b1;
    load_keyiv(80'h0, 80'h0, 1'b0, rdy_ok);
    for (int c = 0; c < 2600 && !(w1 == 1024 && w8 == 128 && w64 == 16); c++) begin
      if (ks_valid1 && w1 < 1024) begin
        got1[w1] = ks_data1[0];
        if (ks_data1[0] !== ref_bits[w1]) bad1++;
        w1++;
      end
      if (ks_valid8 && w8 < 128) begin
        if (ks_data8 !== exp8(w8)) bad8++;
        w8++;
      end
      if (ks_valid64 && w64 < 16) begin
        got64[w64] = ks_data64;
        if (ks_data64 !== exp64(w64)) bad64++;
        w64++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (w1 != 1024 || w8 != 128 || w64 != 16) begin
      n_fail++; $display("FAIL golden_word_counts got=%0d/%0d/%0d exp=1024/128/16", w1, w8, w64);
    end
    n_checks++;
    if (bad1 != 0) begin
      n_fail++; $display("FAIL golden_w1_bits got=%0d bad exp=0", bad1);
    end
    n_checks++;
    if (bad8 != 0) begin
      n_fail++; $display("FAIL golden_w8_words got=%0d bad exp=0", bad8);
    end
    n_checks++;
    if (bad64 != 0) begin
      n_fail++; $display("FAIL golden_w64_words got=%0d bad exp=0", bad64);
    end
    for (int w = 0; w < w64; w++)
      for (int j = 0; j < 64; j++)
        if (w*64+j < w1 && got64[w][j] !== got1[w*64+j]) badp++;
    n_checks++;
    if (badp != 0) begin
      n_fail++; $display("FAIL golden_w64_vs_w1_packing got=%0d bad exp=0", badp);
    end
  endtask

  task automatic test_abort();
    int n;
    bit rdy_ok;
    load_keyiv(K1, I1, 1'b0, rdy_ok);
    repeat (50) @(negedge clk);
    n_checks++;
    if ({busy8, ks_valid8} !== 2'b10) begin
      n_fail++; $display("FAIL abort_in_init got=%b exp=10", {busy8, ks_valid8});
    end
    model_gen(K2, I2);
    load_keyiv(K2, I2, 1'b1, rdy_ok);
    n_checks++;
    if (rdy_ok !== 1'b1) begin
      n_fail++; $display("FAIL abort_cfg_ready got=%b exp=1", rdy_ok);
    end
    n = 0;
    while (!ks_valid8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != 145) begin
      n_fail++; $display("FAIL abort_first_valid got=%0d exp=145", n);
    end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(w)) begin
        n_fail++; $display("FAIL abort_word%0d got=%b/%h exp=1/%h", w, ks_valid8, ks_data8, exp8(w));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ena();
    int n;
    bit rdy_ok;
    load_keyiv(K2, I2, 1'b0, rdy_ok);
    n = 0;
    while (!ks_valid8 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 20) ena = 1'b0;
      if (n == 25) ena = 1'b1;
    end
    ena = 1'b1;
    n_checks++;
    if (n != 150) begin
      n_fail++; $display("FAIL ena_first_valid got=%0d exp=150", n);
    end
    for (int w = 0; w < 4; w++) begin
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(w)) begin
        n_fail++; $display("FAIL ena_pre_word%0d got=%b/%h exp=1/%h", w, ks_valid8, ks_data8, exp8(w));
      end
      @(negedge clk);
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(4)) begin
        n_fail++; $display("FAIL ena_frozen%0d got=%b/%h exp=1/%h", i, ks_valid8, ks_data8, exp8(4));
      end
    end
    ena = 1'b1;
    for (int w = 4; w < 16; w++) begin
      n_checks++;
      if (ks_valid8 !== 1'b1 || ks_data8 !== exp8(w)) begin
        n_fail++; $display("FAIL ena_post_word%0d got=%b/%h exp=1/%h", w, ks_valid8, ks_data8, exp8(w));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    n_checks++;
    if (ks_valid8 !== 1'b1) begin
      n_fail++; $display("FAIL rst_precondition_valid got=%b exp=1", ks_valid8);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ks_valid8, busy8, cfg_ready8} !== 3'b000 || ks_data8 !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_run got=%b/%h exp=000/00", {ks_valid8, busy8, cfg_ready8}, ks_data8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({ks_valid8, busy8, ks_valid64} !== 3'b000) begin
      n_fail++; $display("FAIL rst_stays_idle got=%b exp=000", {ks_valid8, busy8, ks_valid64});
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_backpressure();
    test_golden();
    test_abort();
    test_ena();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
